// File: rtl/pci_defs.sv
// Shared PCI definitions: state encoding and memory command codes used by
// both the initiator (pci_mem_master) and the target-side bridge.
package pci_defs;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StAddr = 3'd2,
    StData = 3'd3,
    StTurn = 3'd4
  } pci_state_e;

  typedef enum logic [1:0] {
    TermNone,
    TermAck,
    TermRty,
    TermErr
  } pci_term_e;

  localparam logic [3:0] CmdMemRead  = 4'b0110;
  localparam logic [3:0] CmdMemWrite = 4'b0111;

  function automatic logic [3:0] mem_cmd(input logic we);
    return we ? CmdMemWrite : CmdMemRead;
  endfunction

endpackage

// File: rtl/pci_mem_master.sv
// Wishbone-slave to PCI initiator bridge: single-data-phase memory read/write
// with retry, target-abort and master-abort (DEVSEL timeout) terminations.
module pci_mem_master
  import pci_defs::*;
#(
  parameter int unsigned DEVSEL_TIMEOUT = 5
) (
  input  logic        pci_clk_i,
  input  logic        pci_rst_ni,
  // Wishbone slave
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [29:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_rty_o,
  output logic        wb_err_o,
  // PCI arbitration
  output logic        pci_req_no,
  input  logic        pci_gnt_ni,
  // PCI initiator controls
  output logic        pci_frame_no,
  output logic        pci_irdy_no,
  output logic        pci_ctl_oe_o,
  // Sampled PCI bus
  input  logic        pci_frame_ni,
  input  logic        pci_irdy_ni,
  input  logic        pci_devsel_ni,
  input  logic        pci_trdy_ni,
  input  logic        pci_stop_ni,
  // AD and C/BE#
  output logic [31:0] pci_ad_o,
  output logic        pci_ad_oe_o,
  input  logic [31:0] pci_ad_i,
  output logic [3:0]  pci_cbe_no,
  output logic        pci_cbe_oe_o
);

  // A 3-bit saturating counter cannot express timeouts beyond 8 clocks.
  localparam int unsigned TimeoutLim = (DEVSEL_TIMEOUT > 8) ? 8 : DEVSEL_TIMEOUT;

  pci_state_e state_q, state_d;
  pci_term_e  term;

  logic [2:0]  cnt_q, cnt_d, cnt_inc;
  logic        seen_q, seen_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic        timeout_hit;

  logic        req_q, req_d;
  logic        frame_q, frame_d;
  logic        irdy_q, irdy_d;
  logic        ctl_oe_q, ctl_oe_d;
  logic [31:0] ad_q, ad_d;
  logic        ad_oe_q, ad_oe_d;
  logic [3:0]  cbe_q, cbe_d;
  logic        cbe_oe_q, cbe_oe_d;
  logic        ack_q, ack_d;
  logic        rty_q, rty_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;

  assign cnt_inc     = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
  assign timeout_hit = ({29'd0, cnt_q} + 32'd1) >= 32'(TimeoutLim);

  // Termination decode, in priority order; only meaningful while in DATA.
  always_comb begin
    term = TermNone;
    if (state_q == StData) begin
      if (!pci_devsel_ni && !pci_trdy_ni) begin
        term = TermAck;
      end else if (!pci_stop_ni && pci_trdy_ni && !pci_devsel_ni) begin
        term = TermRty;
      end else if (!pci_stop_ni && pci_devsel_ni) begin
        term = TermErr;
      end else if (!seen_q && pci_devsel_ni && timeout_hit) begin
        term = TermErr;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    unique case (state_q)
      StIdle: begin
        cnt_d  = 3'd0;
        seen_d = 1'b0;
        if (wb_cyc_i && wb_stb_i) state_d = StReq;
      end
      StReq: begin
        if (!pci_gnt_ni && pci_frame_ni && pci_irdy_ni) begin
          state_d = StAddr;
          we_d    = wb_we_i;
          sel_d   = wb_sel_i;
          dat_d   = wb_dat_i;
        end
      end
      StAddr: begin
        state_d = StData;
        cnt_d   = cnt_inc;
      end
      StData: begin
        cnt_d = cnt_inc;
        if (!pci_devsel_ni) seen_d = 1'b1;
        if (term != TermNone) state_d = StTurn;
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    req_d    = 1'b1;
    frame_d  = 1'b1;
    irdy_d   = 1'b1;
    ctl_oe_d = 1'b0;
    ad_d     = 32'd0;
    ad_oe_d  = 1'b0;
    cbe_d    = 4'hF;
    cbe_oe_d = 1'b0;
    unique case (state_d)
      StReq: req_d = 1'b0;
      StAddr: begin
        frame_d  = 1'b0;
        ctl_oe_d = 1'b1;
        ad_d     = {wb_adr_i, 2'b00};
        ad_oe_d  = 1'b1;
        cbe_d    = mem_cmd(wb_we_i);
        cbe_oe_d = 1'b1;
      end
      StData: begin
        irdy_d   = 1'b0;
        ctl_oe_d = 1'b1;
        ad_d     = we_q ? dat_q : 32'd0;
        ad_oe_d  = we_q;
        cbe_d    = ~sel_q;
        cbe_oe_d = 1'b1;
      end
      StTurn:  ctl_oe_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ack_d  = (term == TermAck);
    rty_d  = (term == TermRty);
    err_d  = (term == TermErr);
    rdat_d = rdat_q;
    if (term == TermAck && !we_q) rdat_d = pci_ad_i;
  end

  always_ff @(posedge pci_clk_i or negedge pci_rst_ni) begin
    if (!pci_rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      seen_q   <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= 4'd0;
      dat_q    <= 32'd0;
      req_q    <= 1'b1;
      frame_q  <= 1'b1;
      irdy_q   <= 1'b1;
      ctl_oe_q <= 1'b0;
      ad_q     <= 32'd0;
      ad_oe_q  <= 1'b0;
      cbe_q    <= 4'hF;
      cbe_oe_q <= 1'b0;
      ack_q    <= 1'b0;
      rty_q    <= 1'b0;
      err_q    <= 1'b0;
      rdat_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      req_q    <= req_d;
      frame_q  <= frame_d;
      irdy_q   <= irdy_d;
      ctl_oe_q <= ctl_oe_d;
      ad_q     <= ad_d;
      ad_oe_q  <= ad_oe_d;
      cbe_q    <= cbe_d;
      cbe_oe_q <= cbe_oe_d;
      ack_q    <= ack_d;
      rty_q    <= rty_d;
      err_q    <= err_d;
      rdat_q   <= rdat_d;
    end
  end

  assign pci_req_no   = req_q;
  assign pci_frame_no = frame_q;
  assign pci_irdy_no  = irdy_q;
  assign pci_ctl_oe_o = ctl_oe_q;
  assign pci_ad_o     = ad_q;
  assign pci_ad_oe_o  = ad_oe_q;
  assign pci_cbe_no   = cbe_q;
  assign pci_cbe_oe_o = cbe_oe_q;
  assign wb_ack_o     = ack_q;
  assign wb_rty_o     = rty_q;
  assign wb_err_o     = err_q;
  assign wb_dat_o     = rdat_q;

endmodule

// File: tb/tb_pci_mem_master.sv
// Scoreboard bench for pci_mem_master: a simple PCI target model answers each
// transaction; expected Wishbone terminations are queued and matched on output.
module tb_pci_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [29:0] wb_adr_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_rty_o, wb_err_o;
  logic        pci_req_no, pci_gnt_ni = 1'b1;
  logic        pci_frame_no, pci_irdy_no, pci_ctl_oe_o;
  logic        pci_frame_ni = 1'b1, pci_irdy_ni = 1'b1;
  logic        pci_devsel_ni = 1'b1, pci_trdy_ni = 1'b1, pci_stop_ni = 1'b1;
  logic [31:0] pci_ad_o, pci_ad_i = '0;
  logic        pci_ad_oe_o;
  logic [3:0]  pci_cbe_no;
  logic        pci_cbe_oe_o;

  always #5 clk = ~clk;

  pci_mem_master #(.DEVSEL_TIMEOUT(5)) dut (
    .pci_clk_i    (clk),
    .pci_rst_ni   (rst_n),
    .wb_cyc_i     (wb_cyc_i),
    .wb_stb_i     (wb_stb_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_sel_i     (wb_sel_i),
    .wb_dat_i     (wb_dat_i),
    .wb_dat_o     (wb_dat_o),
    .wb_ack_o     (wb_ack_o),
    .wb_rty_o     (wb_rty_o),
    .wb_err_o     (wb_err_o),
    .pci_req_no   (pci_req_no),
    .pci_gnt_ni   (pci_gnt_ni),
    .pci_frame_no (pci_frame_no),
    .pci_irdy_no  (pci_irdy_no),
    .pci_ctl_oe_o (pci_ctl_oe_o),
    .pci_frame_ni (pci_frame_ni),
    .pci_irdy_ni  (pci_irdy_ni),
    .pci_devsel_ni(pci_devsel_ni),
    .pci_trdy_ni  (pci_trdy_ni),
    .pci_stop_ni  (pci_stop_ni),
    .pci_ad_o     (pci_ad_o),
    .pci_ad_oe_o  (pci_ad_oe_o),
    .pci_ad_i     (pci_ad_i),
    .pci_cbe_no   (pci_cbe_no),
    .pci_cbe_oe_o (pci_cbe_oe_o)
  );

  // term is {ack, rty, err}
  typedef struct packed {
    logic [2:0]  term;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;

  localparam int RespNone = 0, RespDone = 1, RespRetry = 2, RespTabort = 3, RespDiscData = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
  endtask

  always @(negedge clk) begin
    if (rst_n && (wb_ack_o || wb_rty_o || wb_err_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_term", {29'd0, wb_ack_o, wb_rty_o, wb_err_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("term_kind", {29'd0, wb_ack_o, wb_rty_o, wb_err_o}, {29'd0, mon_e.term});
        if (mon_e.chk_data) check("rd_data", wb_dat_o, mon_e.data);
      end
    end
  end

  task automatic run_txn(input string name, input logic we, input logic [29:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input int gnt_delay,
                         input int resp, input int d, input int exp_lat);
    int   k;
    exp_t e;
    e.term     = (resp == RespDone || resp == RespDiscData) ? 3'b100 :
                 (resp == RespRetry) ? 3'b010 : 3'b001;
    e.chk_data = (e.term == 3'b100) && !we;
    e.data     = dat;
    exp_q.push_back(e);

    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = we ? dat : 32'h0BAD_0BAD;
    pci_gnt_ni = 1'b1;

    k = 0;
    while (pci_req_no && k < 10) begin @(negedge clk); k++; end
    check({name, "_req"}, {31'd0, pci_req_no}, 32'd0);

    k = 0;
    while (pci_frame_no && k < 20) begin
      if (k == gnt_delay) pci_gnt_ni = 1'b0;
      @(negedge clk); k++;
    end
    pci_gnt_ni = 1'b1;
    check({name, "_gnt_lat"}, k, gnt_delay + 1);
    check({name, "_addr_ad"}, pci_ad_o, {adr, 2'b00});
    check({name, "_addr_cbe"}, {28'd0, pci_cbe_no}, we ? 32'h7 : 32'h6);
    check({name, "_addr_ctl"},
          {27'd0, pci_req_no, pci_irdy_no, pci_ctl_oe_o, pci_ad_oe_o, pci_cbe_oe_o}, 32'h1F);

    // The transaction must use values captured at ADDR, not the live inputs.
    wb_dat_i = ~dat; wb_sel_i = ~sel; wb_adr_i = ~adr; wb_we_i = ~we;

    k = 0;
    while (!(wb_ack_o || wb_rty_o || wb_err_o) && k < 20) begin
      @(negedge clk); k++;
      if (wb_ack_o || wb_rty_o || wb_err_o) break;
      if (k == 1) begin
        check({name, "_data_ctl"},
              {28'd0, pci_frame_no, pci_irdy_no, pci_ctl_oe_o, pci_cbe_oe_o}, 32'hB);
        check({name, "_data_cbe"}, {28'd0, pci_cbe_no}, {28'd0, ~sel});
        if (we) check({name, "_data_ad"}, pci_ad_o, dat);
        if (we) check({name, "_data_adoe"}, {31'd0, pci_ad_oe_o}, 32'd1);
      end
      if (!we) check({name, "_rd_adoe"}, {31'd0, pci_ad_oe_o}, 32'd0);
      if (k == d) begin
        unique case (resp)
          RespDone:     begin pci_devsel_ni = 1'b0; pci_trdy_ni = 1'b0; pci_ad_i = dat; end
          RespRetry:    begin pci_devsel_ni = 1'b0; pci_stop_ni = 1'b0; end
          RespTabort:   pci_stop_ni = 1'b0;
          RespDiscData: begin
            pci_devsel_ni = 1'b0; pci_trdy_ni = 1'b0; pci_stop_ni = 1'b0; pci_ad_i = dat;
          end
          default: ;
        endcase
      end
    end
    check({name, "_lat"}, k, exp_lat);
    check({name, "_turn"},
          {27'd0, pci_frame_no, pci_irdy_no, pci_ctl_oe_o, pci_ad_oe_o, pci_cbe_oe_o}, 32'h1C);

    pci_devsel_ni = 1'b1; pci_trdy_ni = 1'b1; pci_stop_ni = 1'b1; pci_ad_i = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    check({name, "_idle"},
          {26'd0, pci_req_no, pci_frame_no, pci_irdy_no, pci_ctl_oe_o, pci_ad_oe_o,
           pci_cbe_oe_o}, 32'h38);
  endtask

  task automatic reset_in_data();
    int k;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 30'h55; wb_sel_i = 4'hF; wb_dat_i = 32'h1357_9BDF;
    pci_gnt_ni = 1'b0;
    pci_frame_ni = 1'b0;  // bus busy: grant alone must not start the address phase
    k = 0;
    while (pci_req_no && k < 10) begin @(negedge clk); k++; end
    @(negedge clk); @(negedge clk);
    check("busy_hold", {30'd0, pci_req_no, pci_frame_no}, 32'h1);
    pci_frame_ni = 1'b1;
    k = 0;
    while (pci_frame_no && k < 10) begin @(negedge clk); k++; end
    check("busy_release_lat", k, 1);
    @(negedge clk);
    check("rst_pre_data", {31'd0, pci_irdy_no}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_bus_release",
          {26'd0, pci_req_no, pci_frame_no, pci_irdy_no, pci_ctl_oe_o, pci_ad_oe_o,
           pci_cbe_oe_o}, 32'h38);
    check("rst_no_pulse", {29'd0, wb_ack_o, wb_rty_o, wb_err_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; pci_gnt_ni = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl",
          {26'd0, pci_req_no, pci_frame_no, pci_irdy_no, pci_ctl_oe_o, pci_ad_oe_o,
           pci_cbe_oe_o}, 32'h38);
    check("rst_wb", {29'd0, wb_ack_o, wb_rty_o, wb_err_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn("wr", 1'b1, 30'h0000_0040, 32'hDEAD_BEEF, 4'hF, 0, RespDone, 1, 2);
    run_txn("rd", 1'b0, 30'h0000_1234, 32'h1234_5678, 4'h3, 0, RespDone, 1, 2);
    run_txn("mabort", 1'b1, 30'h0000_0100, 32'h0000_A5A5, 4'hF, 0, RespNone, 99, 5);
    run_txn("retry", 1'b0, 30'h0000_0200, 32'hFFFF_0000, 4'h6, 3, RespRetry, 2, 3);
    run_txn("tabort", 1'b1, 30'h0000_0300, 32'h0F0F_0F0F, 4'h1, 0, RespTabort, 1, 2);
    run_txn("discdat", 1'b0, 30'h3FFF_FFFF, 32'hCAFE_F00D, 4'hC, 1, RespDiscData, 3, 4);
    reset_in_data();
    run_txn("rd_after_rst", 1'b0, 30'h0000_0777, 32'h8765_4321, 4'hF, 0, RespDone, 1, 2);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pci_mem_master.md
PCI_MEM_MASTER -- requirements
Module: pci_mem_master

Interface
REQ-001 Parameter DEVSEL_TIMEOUT, default 5, SHALL set the clocks after the address phase without DEVSEL# before master abort.
REQ-002 pci_clk_i  in  1  SHALL be the sole clock; every block output is registered on its rising edge.
REQ-003 pci_rst_ni  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Local port wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  SHALL carry the Wishbone slave request.
REQ-005 wb_adr_i  in  30  SHALL be the word address, driven as PCI AD[31:2], with AD[1:0]=00.
REQ-006 wb_sel_i  in  4; wb_dat_i  in  32  SHALL be the byte enables and the write data.
REQ-007 wb_dat_o  out  32; wb_ack_o, wb_rty_o, wb_err_o  out  1 each  SHALL return the read data and the termination.
REQ-008 pci_req_no  out  1; pci_gnt_ni  in  1  SHALL be the arbitration pair.
REQ-009 pci_frame_no, pci_irdy_no  out  1 each; pci_ctl_oe_o  out  1  SHALL drive the initiator controls, with a shared output enable.
REQ-010 pci_frame_ni, pci_irdy_ni, pci_devsel_ni, pci_trdy_ni, pci_stop_ni  in  1 each  SHALL be the sampled bus signals.
REQ-011 pci_ad_o  out  32; pci_ad_oe_o  out  1; pci_ad_i  in  32  SHALL carry AD.
REQ-012 pci_cbe_no  out  4; pci_cbe_oe_o  out  1  SHALL carry C/BE#.

Function
REQ-013 Each transaction SHALL use a single data phase only: MEMREAD 0110 when wb_we_i=0, MEMWRITE 0111 when wb_we_i=1; no bursts.
REQ-014 States SHALL be IDLE, REQ, ADDR, DATA, TURN.
REQ-015 IDLE->REQ SHALL occur on wb_cyc_i&wb_stb_i; pci_req_no=0 in REQ.
REQ-016 REQ->ADDR SHALL occur when pci_gnt_ni=0 and pci_frame_ni=1 and pci_irdy_ni=1; otherwise the block stays in REQ.
REQ-017 In ADDR the block SHALL drive frame_no=0, irdy_no=1, ad={adr,00}, cbe=cmd, with all oe=1; pci_req_no returns to 1.
REQ-018 In DATA the block SHALL drive frame_no=1, irdy_no=0, cbe=~wb_sel_i, cbe_oe=1.
REQ-019 In DATA, ad_oe SHALL be 1 with ad=wb_dat_i for writes, and ad_oe=0 for reads; the read turnaround cycle is implied by ADDR->DATA.
REQ-020 DATA SHALL stay until termination, with terminations evaluated in this priority order.
REQ-020a Completion, devsel_ni=0&trdy_ni=0, SHALL latch pci_ad_i into wb_dat_o on reads and give wb_ack_o=1.
REQ-020b Retry/disconnect-without-data, stop_ni=0&trdy_ni=1&devsel_ni=0, SHALL give wb_rty_o=1.
REQ-020c Target abort, stop_ni=0&devsel_ni=1, SHALL give wb_err_o=1.
REQ-020d Master abort, DEVSEL_TIMEOUT clocks counted from ADDR with devsel_ni never 0, SHALL give wb_err_o=1.
REQ-021 A disconnect-with-data (stop_ni=0&trdy_ni=0) SHALL be treated as completion.
REQ-022 Each termination SHALL pulse its wb_*_o for exactly one clock, registered, on the clock entering TURN.
REQ-023 In TURN the block SHALL drive irdy_no=1, frame_no=1 with ctl_oe=1 for one clock, and ad_oe=0, cbe_oe=0; it then goes to IDLE with ctl_oe=0.
REQ-024 At most one wb_*_o SHALL be asserted per transaction.
REQ-025 A new request SHALL NOT be accepted in TURN; it enters REQ from IDLE, giving a minimum gap of 1 idle clock.
REQ-026 Once ADDR is entered, wb_* inputs SHALL be captured into registers, and changes on wb_* SHALL NOT affect the bus transaction.
REQ-027 The DEVSEL counter SHALL be 3 bits, saturating, and cleared in IDLE.

Reset
REQ-028 Reset SHALL force state IDLE, and SHALL force pci_req_no, pci_frame_no and pci_irdy_no =1 at once.
REQ-029 Reset SHALL force all *_oe_o=0, wb_ack_o=wb_rty_o=wb_err_o=0, wb_dat_o=0, counter=0.
REQ-030 Reset asserted mid-transaction SHALL release the bus within the same cycle, with no termination pulse.

Structure
REQ-031 PCI command codes (0110, 0111) and the state encodings SHALL live in the shared package pci_defs, shared with the target-side bridge.
REQ-032 The block SHALL be a single flat module; no sub-module.

Verification
REQ-033 Write: adr=0x0000_0040, dat=0xDEADBEEF, sel=F; the target asserts DEVSEL+TRDY 2 clocks after ADDR -> AD=0x100 with cbe=0111 in ADDR, AD=0xDEADBEEF with cbe=0000 in DATA, and one wb_ack_o.
REQ-034 Read: the target returns 0x12345678 with sel=3 -> cbe=1100 in DATA, wb_dat_o=0x12345678 at wb_ack_o, and ad_oe=0 throughout DATA.
REQ-035 No target responds -> wb_err_o exactly 5 clocks after ADDR, and the bus is released via TURN.
REQ-036 STOP# with TRDY# deasserted and DEVSEL# asserted -> wb_rty_o, no ack; stalling the grant until 3 clocks into REQ -> ADDR is delayed 3 clocks.
REQ-037 Reset pulsed during DATA -> all oe=0 and irdy_no=1 immediately, and no wb_* pulse.
